// File: rtl/adpll_pkg.sv
`timescale 1ns/1ps
// Shared types and defaults for the ADPLL lock detector and the ADPLL bench.
package adpll_pkg;

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } lock_state_t;

  localparam int DEF_W          = 10;
  localparam int DEF_TOL        = 2;
  localparam int DEF_LOCK_CNT   = 8;
  localparam int DEF_UNLOCK_CNT = 4;
  localparam int CLK_PERIOD_NS  = 2;

endpackage

// File: rtl/adpll_period_meter.sv
`timescale 1ns/1ps
// Measures the period of one asynchronous input in clk cycles: synchronizer,
// rising-edge detect, saturating counter, period register and valid flag.
module adpll_period_meter
  import adpll_pkg::*;
#(
  parameter int W = DEF_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         sig,
  output logic [W-1:0] period,
  output logic         valid,
  output logic         load,
  output logic         timeout
);

  localparam logic [W-1:0] CNT_MAX = '1;
  localparam logic [W-1:0] ONE     = W'(1);

  logic         sync1;
  logic         sync2;
  logic         sync3;
  logic         edge_det;
  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1    <= 1'b0;
      sync2    <= 1'b0;
      sync3    <= 1'b0;
      edge_det <= 1'b0;
    end else begin
      sync1    <= sig;
      sync2    <= sync1;
      sync3    <= sync2;
      edge_det <= sync2 & ~sync3;
    end
  end

  // A saturated count means no edge for 2^W-1 cycles; an edge landing on that
  // same cycle only restarts the count, since the period would not fit.
  assign timeout = valid && (cnt == CNT_MAX);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt    <= '0;
      period <= '0;
      valid  <= 1'b0;
      load   <= 1'b0;
    end else begin
      load <= 1'b0;
      if (edge_det) begin
        cnt   <= '0;
        valid <= 1'b1;
        if (valid && (cnt != CNT_MAX)) begin
          period <= cnt + ONE;
          load   <= 1'b1;
        end
      end else begin
        if (cnt != CNT_MAX) cnt <= cnt + ONE;
        if (timeout) valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/adpll_lock_detector.sv
`timescale 1ns/1ps
// ADPLL lock detector: compares the ref period against ctrl_period*N_DIV after
// every ref period and runs the SEARCH/ACQUIRE/LOCKED lock state machine.
module adpll_lock_detector
  import adpll_pkg::*;
#(
  parameter int W          = DEF_W,
  parameter int N_DIV      = 1,
  parameter int TOL        = DEF_TOL,
  parameter int LOCK_CNT   = DEF_LOCK_CNT,
  parameter int UNLOCK_CNT = DEF_UNLOCK_CNT
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ref_signal,
  input  logic                ctrl_signal,
  output logic [W-1:0]        ref_period,
  output logic [W-1:0]        ctrl_period,
  output logic signed [W+8:0] period_err,
  output logic                meas_valid,
  output logic                locked,
  output logic                lock_lost
);

  localparam int             EW        = W + 9;
  localparam int             GW        = $clog2(LOCK_CNT + 1);
  localparam int             BW        = $clog2(UNLOCK_CNT + 1);
  localparam logic [7:0]     NDIV8     = 8'(N_DIV);
  localparam logic [EW-1:0]  TOL_E     = EW'(TOL);
  localparam logic [GW-1:0]  GOOD_LAST = GW'(LOCK_CNT - 1);
  localparam logic [BW-1:0]  BAD_LAST  = BW'(UNLOCK_CNT - 1);

  logic                 ref_valid;
  logic                 ref_load;
  logic                 ref_timeout;
  logic                 ctrl_valid;
  logic                 unused_ctrl_load;
  logic                 ctrl_timeout;
  logic [W+7:0]         ctrl_scaled;
  logic signed [EW-1:0] err_next;
  logic [EW-1:0]        err_mag;
  logic                 err_good;
  logic                 do_cmp;
  logic                 any_timeout;
  logic                 cmp_good;
  lock_state_t          state;
  logic [GW-1:0]        good_cnt;
  logic [BW-1:0]        bad_cnt;

  adpll_period_meter #(.W(W)) u_ref_meter (
    .clk     (clk),
    .rst_n   (rst_n),
    .sig     (ref_signal),
    .period  (ref_period),
    .valid   (ref_valid),
    .load    (ref_load),
    .timeout (ref_timeout)
  );

  adpll_period_meter #(.W(W)) u_ctrl_meter (
    .clk     (clk),
    .rst_n   (rst_n),
    .sig     (ctrl_signal),
    .period  (ctrl_period),
    .valid   (ctrl_valid),
    .load    (unused_ctrl_load),
    .timeout (ctrl_timeout)
  );

  // Both periods are registers, so coincident edges already present the new ctrl_period here.
  assign ctrl_scaled = {8'd0, ctrl_period} * {{W{1'b0}}, NDIV8};
  assign err_next    = $signed({9'd0, ref_period}) - $signed({1'b0, ctrl_scaled});
  assign err_mag     = err_next[EW-1] ? $unsigned(-err_next) : $unsigned(err_next);
  assign err_good    = (err_mag <= TOL_E);
  assign do_cmp      = ref_load && ref_valid && ctrl_valid;
  assign any_timeout = ref_timeout || ctrl_timeout;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      period_err <= '0;
      meas_valid <= 1'b0;
      cmp_good   <= 1'b0;
    end else begin
      meas_valid <= do_cmp;
      if (do_cmp) begin
        period_err <= err_next;
        cmp_good   <= err_good;
      end
    end
  end

  // Timeout overrides any comparison presented in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= SEARCH;
      good_cnt  <= '0;
      bad_cnt   <= '0;
      locked    <= 1'b0;
      lock_lost <= 1'b0;
    end else begin
      lock_lost <= 1'b0;
      if (any_timeout) begin
        lock_lost <= (state == LOCKED);
        state     <= SEARCH;
        good_cnt  <= '0;
        bad_cnt   <= '0;
        locked    <= 1'b0;
      end else if (meas_valid) begin
        case (state)
          SEARCH: begin
            if (cmp_good) begin
              state    <= ACQUIRE;
              good_cnt <= GW'(1);
            end
          end
          ACQUIRE: begin
            if (!cmp_good) begin
              state    <= SEARCH;
              good_cnt <= '0;
            end else if (good_cnt == GOOD_LAST) begin
              state    <= LOCKED;
              locked   <= 1'b1;
              good_cnt <= '0;
              bad_cnt  <= '0;
            end else begin
              good_cnt <= good_cnt + GW'(1);
            end
          end
          LOCKED: begin
            if (cmp_good) begin
              bad_cnt <= '0;
            end else if (bad_cnt == BAD_LAST) begin
              state     <= SEARCH;
              locked    <= 1'b0;
              lock_lost <= 1'b1;
              bad_cnt   <= '0;
            end else begin
              bad_cnt <= bad_cnt + BW'(1);
            end
          end
          default: begin
            state    <= SEARCH;
            good_cnt <= '0;
            bad_cnt  <= '0;
            locked   <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_adpll_lock_detector.sv
`timescale 1ns/1ps
// Self-checking bench for adpll_lock_detector: table of steady-state period
// scenarios plus directed sequences for lock timing, loss of lock, timeout and reset.
module tb_adpll_lock_detector;
  import adpll_pkg::*;

  localparam int W = DEF_W;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ref_signal = 1'b0;
  logic ctrl_signal = 1'b0;

  logic [W-1:0]        ref_period1, ctrl_period1, ref_period4, ctrl_period4;
  logic signed [W+8:0] period_err1, period_err4;
  logic                meas_valid1, locked1, lock_lost1;
  logic                meas_valid4, locked4, lock_lost4;

  adpll_lock_detector #(.W(W), .N_DIV(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .ref_signal(ref_signal), .ctrl_signal(ctrl_signal),
    .ref_period(ref_period1), .ctrl_period(ctrl_period1), .period_err(period_err1),
    .meas_valid(meas_valid1), .locked(locked1), .lock_lost(lock_lost1)
  );

  adpll_lock_detector #(.W(W), .N_DIV(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .ref_signal(ref_signal), .ctrl_signal(ctrl_signal),
    .ref_period(ref_period4), .ctrl_period(ctrl_period4), .period_err(period_err4),
    .meas_valid(meas_valid4), .locked(locked4), .lock_lost(lock_lost4)
  );

  always #(CLK_PERIOD_NS / 2) clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Square-wave sources; each period is latched at its rising edge, edges sit 0.5 ns off the clk grid.
  bit ref_en = 0, ctrl_en = 0;
  int ref_ns = 120, ctrl_ns = 120;
  int ref_q[$];

  initial begin
    int p;
    #0.5;
    forever begin
      if (ref_en) begin
        p = (ref_q.size() > 0) ? ref_q.pop_front() : ref_ns;
        ref_signal = 1'b1; #(p / 2);
        ref_signal = 1'b0; #(p - p / 2);
      end else #2;
    end
  end

  initial begin
    int p;
    #0.5;
    forever begin
      if (ctrl_en) begin
        p = ctrl_ns;
        ctrl_signal = 1'b1; #(p / 2);
        ctrl_signal = 1'b0; #(p - p / 2);
      end else #2;
    end
  end

  int ll_cnt1 = 0, ll_cnt4 = 0;
  bit seen_lock1 = 0, seen_lock4 = 0;
  always @(negedge clk) begin
    if (lock_lost1) ll_cnt1++;
    if (lock_lost4) ll_cnt4++;
    if (locked1) seen_lock1 = 1;
    if (locked4) seen_lock4 = 1;
  end

  initial begin
    #1ms;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic signed [63:0] actual,
                             input logic signed [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input int r_ns, input int c_ns);
    ref_en = 0;
    ctrl_en = 0;
    repeat (80) @(negedge clk);
    rst_n = 1'b0;
    ref_q.delete();
    ref_ns = r_ns;
    ctrl_ns = c_ns;
    repeat (4) @(negedge clk);
    ll_cnt1 = 0; ll_cnt4 = 0; seen_lock1 = 0; seen_lock4 = 0;
    ref_en = 1;
    ctrl_en = 1;
    rst_n = 1'b1;
  endtask

  task automatic waitMeas(input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (meas_valid1) begin ok = 1; break; end
    end
    if (!ok) begin
      checks++; failures++;
      $display("[TB] FAIL meas_wait: no meas_valid within %0d cycles", budget);
    end
  endtask

  task automatic waitLocked(input int budget);
    bit ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (locked1) begin ok = 1; break; end
    end
    checkOutput("lock_wait", ok, 1);
  endtask

  // Expects 8 consecutive zero-error comparisons, lock asserted one cycle after the 8th.
  task automatic waitLockSeq(input string tag);
    bit ok;
    for (int k = 1; k <= DEF_LOCK_CNT; k++) begin
      waitMeas(200, ok);
      checkOutput($sformatf("%s_err%0d", tag, k), period_err1, 0);
      checkOutput($sformatf("%s_prelock%0d", tag, k), locked1, 0);
    end
    @(negedge clk);
    checkOutput($sformatf("%s_lock_rise", tag), locked1, 1);
  endtask

  typedef struct {
    int ref_ns;
    int ctrl_ns;
    bit div4;
    int exp_ref;
    int exp_ctrl;
    int exp_err;
    bit exp_locked;
  } vec_t;

  vec_t vecs[8];
  int   q_err[8];
  bit   q_lock[8];
  bit   q_lost[8];

  initial begin
    bit ok;
    int n;

    vecs[0] = '{120, 120, 1'b0, 60, 60,  0, 1'b1};
    vecs[1] = '{120, 124, 1'b0, 60, 62, -2, 1'b1};
    vecs[2] = '{120, 126, 1'b0, 60, 63, -3, 1'b0};
    vecs[3] = '{120, 116, 1'b0, 60, 58,  2, 1'b1};
    vecs[4] = '{120, 114, 1'b0, 60, 57,  3, 1'b0};
    vecs[5] = '{120,  30, 1'b1, 60, 15,  0, 1'b1};
    vecs[6] = '{120,  32, 1'b1, 60, 16, -4, 1'b0};
    vecs[7] = '{120,  28, 1'b1, 60, 14,  4, 1'b0};

    q_err  = '{0, 5, 5, 0, 5, 5, 5, 5};
    q_lock = '{1, 1, 1, 1, 1, 1, 1, 0};
    q_lost = '{0, 0, 0, 0, 0, 0, 0, 1};

    // Reset state
    repeat (3) @(negedge clk);
    checkOutput("rst_ref_period", ref_period1, 0);
    checkOutput("rst_ctrl_period", ctrl_period1, 0);
    checkOutput("rst_period_err", period_err1, 0);
    checkOutput("rst_meas_valid", meas_valid1, 0);
    checkOutput("rst_locked", locked1, 0);
    checkOutput("rst_lock_lost", lock_lost1, 0);

    // Steady-state scenarios
    for (int v = 0; v < 8; v++) begin
      applyStimulus(vecs[v].ref_ns, vecs[v].ctrl_ns);
      repeat (900) @(negedge clk);
      if (vecs[v].div4) begin
        checkOutput($sformatf("v%0d_ref_period", v), ref_period4, vecs[v].exp_ref);
        checkOutput($sformatf("v%0d_ctrl_period", v), ctrl_period4, vecs[v].exp_ctrl);
        checkOutput($sformatf("v%0d_period_err", v), period_err4, vecs[v].exp_err);
        checkOutput($sformatf("v%0d_locked", v), locked4, vecs[v].exp_locked);
        checkOutput($sformatf("v%0d_ever_locked", v), seen_lock4, vecs[v].exp_locked);
        checkOutput($sformatf("v%0d_lock_lost_cnt", v), ll_cnt4, 0);
      end else begin
        checkOutput($sformatf("v%0d_ref_period", v), ref_period1, vecs[v].exp_ref);
        checkOutput($sformatf("v%0d_ctrl_period", v), ctrl_period1, vecs[v].exp_ctrl);
        checkOutput($sformatf("v%0d_period_err", v), period_err1, vecs[v].exp_err);
        checkOutput($sformatf("v%0d_locked", v), locked1, vecs[v].exp_locked);
        checkOutput($sformatf("v%0d_ever_locked", v), seen_lock1, vecs[v].exp_locked);
        checkOutput($sformatf("v%0d_lock_lost_cnt", v), ll_cnt1, 0);
      end
    end

    // Lock timing, then bad/good/bad ref periods while locked
    applyStimulus(120, 120);
    waitLockSeq("nominal");
    waitMeas(200, ok);
    ref_q = '{130, 130, 120, 130, 130, 130, 130};
    for (int k = 0; k < 8; k++) begin
      waitMeas(200, ok);
      checkOutput($sformatf("slip_err%0d", k), period_err1, q_err[k]);
      @(negedge clk);
      checkOutput($sformatf("slip_locked%0d", k), locked1, q_lock[k]);
      checkOutput($sformatf("slip_lost%0d", k), lock_lost1, q_lost[k]);
    end
    repeat (3) @(negedge clk);
    checkOutput("slip_lost_total", ll_cnt1, 1);

    // Ctrl frequency step while locked
    applyStimulus(120, 120);
    waitLocked(1000);
    ctrl_ns = 130;
    ok = 0;
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      if (lock_lost1) begin ok = 1; break; end
    end
    checkOutput("step_lost_seen", ok, 1);
    checkOutput("step_period_err", period_err1, -5);
    checkOutput("step_ctrl_period", ctrl_period1, 65);
    checkOutput("step_locked", locked1, 0);
    @(negedge clk);
    checkOutput("step_lost_width", lock_lost1, 0);

    // Ctrl timeout while locked, then restart
    applyStimulus(120, 120);
    waitLocked(1000);
    ctrl_en = 0;
    ok = 0;
    n = 0;
    for (int i = 0; i < 1300; i++) begin
      @(negedge clk);
      n++;
      if (lock_lost1) begin ok = 1; break; end
    end
    checkOutput("tmo_lost_seen", ok, 1);
    checkOutput("tmo_window", (n >= 1000 && n <= 1100), 1);
    checkOutput("tmo_locked", locked1, 0);
    checkOutput("tmo_ctrl_period", ctrl_period1, 60);
    @(negedge clk);
    checkOutput("tmo_lost_width", lock_lost1, 0);
    ctrl_en = 1;
    waitLockSeq("relock");

    // Reset pulse mid-lock, issued while ref is low
    waitMeas(200, ok);
    repeat (40) @(negedge clk);
    checkOutput("mid_pre_locked", locked1, 1);
    ll_cnt1 = 0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checkOutput("mid_locked", locked1, 0);
    checkOutput("mid_ref_period", ref_period1, 0);
    checkOutput("mid_ctrl_period", ctrl_period1, 0);
    checkOutput("mid_period_err", period_err1, 0);
    checkOutput("mid_meas_valid", meas_valid1, 0);
    checkOutput("mid_lock_lost", lock_lost1, 0);
    n = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      n++;
      if (ref_period1 != 0) break;
    end
    checkOutput("mid_first_load_late", (n >= 60), 1);
    checkOutput("mid_first_period", ref_period1, 60);
    checkOutput("mid_no_lost", ll_cnt1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
